// File: rtl/iterative_shifter_pkg.sv
// Shared types for the execute-stage shifter: op encoding and FSM state.
// The decoder and ALU also use this package.
package iterative_shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/iterative_shifter_if.sv
// Request/response handshake bundle for the iterative shifter.
// The master side is the producer/consumer; the slave side is the shifter.
interface iterative_shifter_if
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  shift_op_e        in_op;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_op, in_data, in_shamt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/iterative_shifter_shift_step.sv
// Combinational shift of 0..STEP bits for one op; one pass of the iterative loop.
module shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  shift_op_e        op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] rot_s;

  // Select the shifted word; rotation comes from the low half of the doubled operand
  always_comb begin
    rot_s  = {data, data} >> amt;
    result = data;
    case (op)
      SH_SLL:  result = data << amt;
      SH_SRL:  result = data >> amt;
      SH_SRA:  result = WIDTH'($signed(data) >>> amt);
      SH_ROR:  result = rot_s[WIDTH-1:0];
      default: result = data;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR unit: shifts up to STEP bits per cycle, one op in flight,
// valid/ready on both sides with registered handshake outputs.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  iterative_shifter_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int AW  = $clog2(STEP + 1);
  localparam logic [SHW-1:0] STEP_C = SHW'(STEP);

  shift_state_e     state_r;
  shift_op_e        op_r;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   rem_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [SHW-1:0]   amt_full_s;
  logic [AW-1:0]    amt_s;
  logic [WIDTH-1:0] step_data_s;

  // Bits to move this cycle: min(remaining, STEP)
  always_comb begin
    amt_full_s = STEP_C;
    if (rem_r < STEP_C) begin
      amt_full_s = rem_r;
    end else begin
      amt_full_s = STEP_C;
    end
  end

  assign amt_s = AW'(amt_full_s);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AW    (AW)
  ) u_step (
    .op     (op_r),
    .amt    (amt_s),
    .data   (data_r),
    .result (step_data_s)
  );

  // FSM, operand register and remaining count; flush overrides every other event
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      op_r        <= SH_SLL;
      data_r      <= '0;
      rem_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= ST_IDLE;
      rem_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            op_r       <= bus.in_op;
            data_r     <= bus.in_data;
            rem_r      <= bus.in_shamt;
            in_ready_r <= 1'b0;
            if (bus.in_shamt == '0) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_r <= step_data_s;
          rem_r  <= rem_r - amt_full_s;
          if (rem_r == amt_full_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = data_r;

endmodule

// File: tb/tb_iterative_shifter.sv
// Randomised self-checking bench: STEP=1 and STEP=4 instances against a plain-arithmetic model.
module tb_iterative_shifter;
  import iterative_shifter_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  logic flush;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  iterative_shifter_if #(.WIDTH(32)) if1 ();
  iterative_shifter_if #(.WIDTH(32)) if4 ();

  iterative_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(if1));
  iterative_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(if4));

  always #5 clock = ~clock;

  // Reference model written from the fill rules, bit by bit
  function automatic logic [31:0] ref_shift(shift_op_e op, logic [31:0] d, int s);
    logic [31:0] r;
    r = d;
    case (op)
      SH_SLL: r = d << s;
      SH_SRL: r = d >> s;
      SH_SRA: begin
        r = d >> s;
        for (int i = 0; i < s; i++) r[31-i] = d[31];
      end
      SH_ROR: for (int i = 0; i < 32; i++) r[i] = d[(i + s) % 32];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(int s, int step);
    return 1 + (s + step - 1) / step;
  endfunction

  task automatic set_req(input bit sel, input logic v, input shift_op_e op,
                         input logic [31:0] d, input logic [4:0] s);
    if (sel) begin
      if4.in_valid = v; if4.in_op = op; if4.in_data = d; if4.in_shamt = s;
    end else begin
      if1.in_valid = v; if1.in_op = op; if1.in_data = d; if1.in_shamt = s;
    end
  endtask

  task automatic set_ordy(input bit sel, input logic r);
    if (sel) if4.out_ready = r;
    else     if1.out_ready = r;
  endtask

  function automatic logic vld(bit sel);
    return sel ? if4.out_valid : if1.out_valid;
  endfunction

  function automatic logic rdy(bit sel);
    return sel ? if4.in_ready : if1.in_ready;
  endfunction

  function automatic logic [31:0] dat(bit sel);
    return sel ? if4.out_data : if1.out_data;
  endfunction

  // Issue one op with out_ready high; report result, latency and in_ready after the handshake
  task automatic do_op(input bit sel, input shift_op_e op, input logic [31:0] d,
                       input logic [4:0] s, output logic [31:0] res, output int lat,
                       output logic rdy_after);
    set_ordy(sel, 1'b1);
    set_req(sel, 1'b1, op, d, s);
    @(posedge clock); #1;
    set_req(sel, 1'b0, shift_op_e'($urandom_range(3)), $urandom, 5'($urandom));
    lat = 1;
    while (!vld(sel) && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    res = dat(sel);
    @(posedge clock); #1;
    rdy_after = rdy(sel);
  endtask

  task automatic test_reset();
    chk_cnt++;
    if (if1.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", if1.in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (if1.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", if1.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (if1.out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", if1.out_data);
    else pass_cnt++;
    chk_cnt++;
    if (if4.in_ready !== 1'b1) $display("FAIL reset_in_ready4: got %b want 1", if4.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_sra_corner();
    logic [31:0] res; int lat; logic ra;
    do_op(1'b0, SH_SRA, 32'h8000_0000, 5'd31, res, lat, ra);
    chk_cnt++;
    if (res !== 32'hFFFF_FFFF) $display("FAIL sra31_data: got %h want ffffffff", res);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 32) $display("FAIL sra31_latency: got %0d want 32", lat);
    else pass_cnt++;
  endtask

  task automatic test_zero_shamt();
    logic [31:0] res; int lat; logic ra;
    for (int op = 0; op < 4; op++) begin
      do_op(1'b0, shift_op_e'(op), 32'h1234_5678, 5'd0, res, lat, ra);
      chk_cnt++;
      if (res !== 32'h1234_5678) $display("FAIL zero_data op%0d: got %h want 12345678", op, res);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== 1) $display("FAIL zero_latency op%0d: got %0d want 1", op, lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_step4();
    logic [31:0] res; int lat; logic ra;
    do_op(1'b1, SH_ROR, 32'h0000_000F, 5'd6, res, lat, ra);
    chk_cnt++;
    if (res !== 32'h3C00_0000) $display("FAIL step4_ror_data: got %h want 3c000000", res);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 3) $display("FAIL step4_ror_latency: got %0d want 3", lat);
    else pass_cnt++;
    do_op(1'b1, SH_SLL, 32'h0000_0001, 5'd31, res, lat, ra);
    chk_cnt++;
    if (res !== 32'h8000_0000) $display("FAIL step4_sll_data: got %h want 80000000", res);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 9) $display("FAIL step4_sll_latency: got %0d want 9", lat);
    else pass_cnt++;
  endtask

  // Random ops issued back to back on both instances
  task automatic test_random();
    logic [31:0] res, d; int lat, s, step; logic ra; shift_op_e op;
    for (int n = 0; n < 60; n++) begin
      bit sel;
      sel  = n[0];
      step = sel ? 4 : 1;
      op   = shift_op_e'($urandom_range(3));
      d    = $urandom;
      s    = $urandom_range(31);
      do_op(sel, op, d, 5'(s), res, lat, ra);
      chk_cnt++;
      if (res !== ref_shift(op, d, s))
        $display("FAIL rand_data step%0d op%0d d=%h s=%0d: got %h want %h",
                 step, op, d, s, res, ref_shift(op, d, s));
      else pass_cnt++;
      chk_cnt++;
      if (lat !== ref_lat(s, step))
        $display("FAIL rand_latency step%0d s=%0d: got %0d want %0d", step, s, lat, ref_lat(s, step));
      else pass_cnt++;
      chk_cnt++;
      if (ra !== 1'b1) $display("FAIL rand_in_ready_after step%0d: got %b want 1", step, ra);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold_done();
    logic [31:0] held; int w;
    set_ordy(1'b0, 1'b0);
    set_req(1'b0, 1'b1, SH_SLL, 32'h0000_00A5, 5'd3);
    @(posedge clock); #1;
    set_req(1'b0, 1'b0, SH_SLL, 32'h0, 5'd0);
    w = 0;
    while (!vld(1'b0) && w < 20) begin @(posedge clock); #1; w++; end
    held = if1.out_data;
    chk_cnt++;
    if (held !== 32'h0000_0528) $display("FAIL hold_data: got %h want 00000528", held);
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      set_req(1'b0, 1'b1, SH_ROR, $urandom, 5'($urandom_range(31)));
      @(posedge clock); #1;
      chk_cnt++;
      if (if1.out_valid !== 1'b1 || if1.out_data !== held || if1.in_ready !== 1'b0)
        $display("FAIL hold_stable c%0d: got v=%b d=%h r=%b want v=1 d=%h r=0",
                 c, if1.out_valid, if1.out_data, if1.in_ready, held);
      else pass_cnt++;
    end
    set_req(1'b0, 1'b0, SH_SLL, 32'h0, 5'd0);
    set_ordy(1'b0, 1'b1);
    @(posedge clock); #1;
    chk_cnt++;
    if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1)
      $display("FAIL hold_release: got v=%b r=%b want v=0 r=1", if1.out_valid, if1.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int lat; logic ra;
    set_ordy(1'b0, 1'b1);
    set_req(1'b0, 1'b1, SH_SRL, 32'hDEAD_BEEF, 5'd20);
    @(posedge clock); #1;
    set_req(1'b0, 1'b0, SH_SRL, 32'h0, 5'd0);
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1 || if1.out_data !== 32'h0)
      $display("FAIL reset_mid: got v=%b r=%b d=%h want v=0 r=1 d=0",
               if1.out_valid, if1.in_ready, if1.out_data);
    else pass_cnt++;
    @(posedge clock); #1 reset_n = 1'b1;
    do_op(1'b0, SH_SRL, 32'h0000_00F0, 5'd4, res, lat, ra);
    chk_cnt++;
    if (res !== 32'h0000_000F) $display("FAIL reset_fresh_op: got %h want 0000000f", res);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int w; int seen;
    set_ordy(1'b0, 1'b0);
    set_req(1'b0, 1'b1, SH_SRA, 32'h1111_2222, 5'd2);
    @(posedge clock); #1;
    set_req(1'b0, 1'b0, SH_SLL, 32'h0, 5'd0);
    w = 0;
    while (!vld(1'b0) && w < 20) begin @(posedge clock); #1; w++; end
    flush = 1'b1;
    set_ordy(1'b0, 1'b1);
    set_req(1'b0, 1'b1, SH_SLL, 32'h0000_AAAA, 5'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    set_req(1'b0, 1'b0, SH_SLL, 32'h0, 5'd0);
    chk_cnt++;
    if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1)
      $display("FAIL flush_done: got v=%b r=%b want v=0 r=1", if1.out_valid, if1.in_ready);
    else pass_cnt++;
    @(posedge clock); #1;
    chk_cnt++;
    if (if1.out_valid !== 1'b0) $display("FAIL flush_no_accept: got v=%b want 0", if1.out_valid);
    else pass_cnt++;
    // Flush mid-shift: the aborted op must never surface
    set_req(1'b0, 1'b1, SH_SLL, 32'h1, 5'd20);
    @(posedge clock); #1;
    set_req(1'b0, 1'b0, SH_SLL, 32'h0, 5'd0);
    repeat (3) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (if1.out_valid) seen++;
      @(posedge clock); #1;
    end
    chk_cnt++;
    if (seen !== 0 || if1.in_ready !== 1'b1)
      $display("FAIL flush_shift: got valid_cycles=%0d r=%b want 0 r=1", seen, if1.in_ready);
    else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    set_req(1'b0, 1'b0, SH_SLL, 32'h0, 5'd0);
    set_req(1'b1, 1'b0, SH_SLL, 32'h0, 5'd0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    test_sra_corner();
    test_zero_shamt();
    test_step4();
    test_random();
    test_hold_done();
    test_reset_mid();
    test_flush();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
